i3c_line_conditioner: RTL and testbench
=======================================

Name: i3c_line_conditioner

Overview:
Front-end conditioning stage for the raw SCL/SDA inputs. It synchronises each line into clk_i and rejects spikes shorter than a programmable width. It then presents clean line levels plus one-cycle rising/falling edge pulses. The downstream edge detectors and bus-condition logic use the pulses as their `trigger` inputs and the filtered levels as their `line` inputs.

Parameters:
CNTR_W, 20, width of the spike-filter length input and the internal filter counters
SYNC_STAGES, 2, number of synchroniser flops per line; legal values are 2 or more
GLITCH_CNT_W, 8, width of the saturating per-line rejected-spike counters

Ports:
clk_i  input  1  core clock
rst_ni  input  1  reset; asynchronous, active-low
scl_i  input  1  raw SCL from pad, asynchronous to clk_i
sda_i  input  1  raw SDA from pad, asynchronous to clk_i
enable_i  input  1  conditioner enable
filter_len_i  input  CNTR_W  spike-filter length in clk_i cycles; 0 = no filtering beyond the synchroniser
glitch_clr_i  input  1  synchronous clear of both glitch counters
scl_o  output  1  filtered SCL level
sda_o  output  1  filtered SDA level
scl_posedge_o  output  1  1-cycle pulse when scl_o rises
scl_negedge_o  output  1  1-cycle pulse when scl_o falls
sda_posedge_o  output  1  1-cycle pulse when sda_o rises
sda_negedge_o  output  1  1-cycle pulse when sda_o falls
scl_glitch_cnt_o  output  GLITCH_CNT_W  number of rejected SCL spikes, saturating
sda_glitch_cnt_o  output  GLITCH_CNT_W  number of rejected SDA spikes, saturating

Behaviour:
- Reset values: all synchroniser flops 1; scl_o and sda_o 1 (bus idle, pulled up); all edge pulses 0; filter counters 0; glitch counters 0.
- SCL and SDA are processed by identical, independent paths. Per line: s = last synchroniser stage, f = filtered level (drives *_o), c = CNTR_W-bit filter counter.
- Per-cycle update when enable_i=1:
  - s == f: c <= 0. If c was nonzero, the glitch counter increments (saturating at all-ones).
  - s != f and c >= filter_len_i: f <= s, c <= 0. Assert the matching posedge/negedge pulse in the same cycle f takes its new value.
  - s != f and c < filter_len_i: c <= c+1.
- Latency:
  - A clean level change on the pin appears on s after SYNC_STAGES cycles.
  - f follows filter_len_i+1 cycles later. Total = SYNC_STAGES + filter_len_i + 1 cycles.
  - A spike with s != f for at most filter_len_i consecutive cycles is rejected and counted once.
- filter_len_i is sampled every cycle with no shadowing.
  - Lowering it mid-count causes acceptance on the next cycle, because the comparison is >=.
  - Raising it extends the current count window.
- Pulses are strictly one cycle wide. Posedge and negedge of one line are never high together.
- SCL and SDA pulses in the same cycle are legal and both asserted.
- enable_i=0:
  - Synchronisers keep running.
  - f forced to 1, c held at 0, no pulses.
  - Glitch counters hold their value.
- On enable_i rising: filtering restarts from f=1. If s=0, a negedge pulse follows after filter_len_i+1 cycles.
- glitch_clr_i=1 zeroes both glitch counters next cycle. Clear wins over a simultaneous increment.
- Saturation: once a counter is at all-ones, further rejected spikes leave it unchanged; no wrap.
- Reset asserted mid-operation returns every flop to its reset value immediately (asynchronous). No pulse is generated on reset release.

Decomposition:
- controller_pkg gains the default constants I3C_SYNC_STAGES=2 and I3C_GLITCH_CNT_W=8. They are used as parameter defaults here and by instantiating wrappers.
- Natural sub-module: line_filter, containing one synchroniser, filter counter, edge-pulse generator and glitch counter. It is instantiated twice (SCL, SDA). The top level only handles enable/clear fan-out and port mapping.

Test Plan:
1. Reset release with scl_i=sda_i=1, filter_len_i=4 -> scl_o=sda_o=1, no pulses, glitch counts 0 for 20 cycles.
2. sda_i 1->0 held, filter_len_i=4, SYNC_STAGES=2 -> sda_negedge_o high for exactly one cycle, 7 cycles after the pin change. sda_o=0 from that cycle; sda_glitch_cnt_o stays 0.
3. scl_i low spike of 3 cycles, filter_len_i=4 -> no scl pulse, scl_o stays 1, scl_glitch_cnt_o becomes 1. Repeat with a 5-cycle spike -> scl_negedge_o then scl_posedge_o, glitch count still 1.
4. filter_len_i=0, sda_i toggled every 4 cycles -> every transition passes with latency 3 and one pulse each. Same-cycle SCL and SDA transitions give simultaneous pulses on both lines.
5. 300 rejected SDA spikes -> sda_glitch_cnt_o saturates at 255. glitch_clr_i asserted in the same cycle as a further spike -> count 0.
6. enable_i=0 with sda_i=0 -> sda_o=1, no pulses. Raise enable_i with filter_len_i=2 -> sda_negedge_o 3 cycles later. Assert rst_ni=0 mid-count -> immediate return to reset values.

Source files
------------

// File: rtl/i3c_line_conditioner_pkg.sv
// ---------------------------------------------------------------------------
// i3c_line_conditioner_pkg
// Purpose : Shared constants and types for the I3C SCL/SDA line conditioner.
//           The default constants are also used by wrappers that instantiate
//           the conditioner.
// Contents:
//   I3C_SYNC_STAGES   default synchroniser depth per line
//   I3C_GLITCH_CNT_W  default width of the rejected-spike counters
//   I3C_CNTR_W        default width of the spike-filter length and counters
//   I3C_NUM_LINES     number of conditioned lines (SCL, SDA)
//   I3C_IDX_SCL/SDA   lane index of each line inside the top level
//   i3c_line_t        filtered level plus its edge pulses for one line
// ---------------------------------------------------------------------------
package i3c_line_conditioner_pkg;

  localparam int I3C_SYNC_STAGES  = 2;
  localparam int I3C_GLITCH_CNT_W = 8;
  localparam int I3C_CNTR_W       = 20;

  localparam int I3C_NUM_LINES = 2;
  localparam int I3C_IDX_SCL   = 0;
  localparam int I3C_IDX_SDA   = 1;

  typedef struct packed {
    logic level;  // filtered line level
    logic rise;   // one-cycle pulse when level goes 0 -> 1
    logic fall;   // one-cycle pulse when level goes 1 -> 0
  } i3c_line_t;

endpackage

// File: rtl/i3c_line_conditioner_line_filter.sv
// ---------------------------------------------------------------------------
// i3c_line_conditioner_line_filter
// Purpose : Conditions one raw open-drain bus line. The raw pin goes through
//           a multi-flop synchroniser, a programmable spike filter and an
//           edge-pulse generator. Spikes that the filter rejects are counted
//           in a saturating counter.
// Ports   :
//   clk_i          core clock
//   rst_ni         asynchronous active-low reset
//   line_i         raw pad level, asynchronous to clk_i
//   enable_i       1 = filter active; 0 = output parked high, counter held
//   filter_len_i   a change is accepted once it has persisted this many
//                  cycles plus one; 0 = accept on the first cycle
//   glitch_clr_i   synchronous clear of the rejected-spike counter
//   line_o         filtered level
//   posedge_o      one-cycle pulse in the cycle line_o becomes 1
//   negedge_o      one-cycle pulse in the cycle line_o becomes 0
//   glitch_cnt_o   number of rejected spikes, saturating at all-ones
// ---------------------------------------------------------------------------
module i3c_line_conditioner_line_filter #(
  parameter int CNTR_W       = 20,
  parameter int SYNC_STAGES  = 2,
  parameter int GLITCH_CNT_W = 8
) (
  input  logic                    clk_i,
  input  logic                    rst_ni,
  input  logic                    line_i,
  input  logic                    enable_i,
  input  logic [CNTR_W-1:0]       filter_len_i,
  input  logic                    glitch_clr_i,
  output logic                    line_o,
  output logic                    posedge_o,
  output logic                    negedge_o,
  output logic [GLITCH_CNT_W-1:0] glitch_cnt_o
);

  // Synchroniser: r_sync[0] samples the pad, r_sync[SYNC_STAGES-1] is the
  // settled level used by the filter. Resets to 1 (idle, pulled-up bus).
  logic [SYNC_STAGES-1:0]  r_sync;
  logic                    r_filt;
  logic [CNTR_W-1:0]       r_cnt;
  logic                    r_pos;
  logic                    r_neg;
  logic [GLITCH_CNT_W-1:0] r_glitch;

  logic                    w_s;
  logic                    w_mismatch;
  logic                    w_accept;
  logic                    w_reject;
  logic                    w_filt_next;
  logic [CNTR_W-1:0]       w_cnt_next;
  logic                    w_pos_next;
  logic                    w_neg_next;
  logic [GLITCH_CNT_W-1:0] w_glitch_next;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_sync <= '1;
    end else begin
      r_sync <= {r_sync[SYNC_STAGES-2:0], line_i};
    end
  end

  assign w_s        = r_sync[SYNC_STAGES-1];
  assign w_mismatch = (w_s != r_filt);
  // >= rather than == so that lowering filter_len_i below the running count
  // accepts the pending change on the next cycle instead of stalling it.
  assign w_accept   = enable_i && w_mismatch && (r_cnt >= filter_len_i);
  // The line fell back to the filtered level before the count completed:
  // that excursion was a spike.
  assign w_reject   = enable_i && !w_mismatch && (r_cnt != '0);

  always_comb begin
    w_filt_next = r_filt;
    w_cnt_next  = r_cnt;
    w_pos_next  = 1'b0;
    w_neg_next  = 1'b0;
    if (!enable_i) begin
      // Disabled: park the output at the idle level without producing edges.
      w_filt_next = 1'b1;
      w_cnt_next  = '0;
    end else if (!w_mismatch) begin
      w_cnt_next = '0;
    end else if (w_accept) begin
      w_filt_next = w_s;
      w_cnt_next  = '0;
      w_pos_next  = w_s;
      w_neg_next  = !w_s;
    end else begin
      // Cannot overflow: r_cnt < filter_len_i on this path.
      w_cnt_next = r_cnt + CNTR_W'(1);
    end
  end

  always_comb begin
    w_glitch_next = r_glitch;
    if (glitch_clr_i) begin
      w_glitch_next = '0;
    end else if (w_reject && (r_glitch != '1)) begin
      w_glitch_next = r_glitch + GLITCH_CNT_W'(1);
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_filt   <= 1'b1;
      r_cnt    <= '0;
      r_pos    <= 1'b0;
      r_neg    <= 1'b0;
      r_glitch <= '0;
    end else begin
      r_filt   <= w_filt_next;
      r_cnt    <= w_cnt_next;
      r_pos    <= w_pos_next;
      r_neg    <= w_neg_next;
      r_glitch <= w_glitch_next;
    end
  end

  assign line_o       = r_filt;
  assign posedge_o    = r_pos;
  assign negedge_o    = r_neg;
  assign glitch_cnt_o = r_glitch;

endmodule

// File: rtl/i3c_line_conditioner.sv
// ---------------------------------------------------------------------------
// i3c_line_conditioner
// Purpose : Front-end conditioning of the raw I3C SCL/SDA pads. Each line is
//           synchronised into clk_i, spike-filtered and turned into a clean
//           level plus one-cycle rise/fall pulses for the downstream edge
//           detectors and bus-condition logic. The two lines are independent.
// Ports   :
//   clk_i, rst_ni           core clock, asynchronous active-low reset
//   scl_i, sda_i            raw pad levels (asynchronous)
//   enable_i                conditioner enable (0 parks outputs high)
//   filter_len_i            spike-filter length in clk_i cycles
//   glitch_clr_i            clears both rejected-spike counters
//   scl_o, sda_o            filtered levels
//   scl/sda_posedge_o       one-cycle rise pulses
//   scl/sda_negedge_o       one-cycle fall pulses
//   scl/sda_glitch_cnt_o    saturating rejected-spike counts
// ---------------------------------------------------------------------------
module i3c_line_conditioner
  import i3c_line_conditioner_pkg::*;
#(
  parameter int CNTR_W       = I3C_CNTR_W,
  parameter int SYNC_STAGES  = I3C_SYNC_STAGES,
  parameter int GLITCH_CNT_W = I3C_GLITCH_CNT_W
) (
  input  logic                    clk_i,
  input  logic                    rst_ni,
  input  logic                    scl_i,
  input  logic                    sda_i,
  input  logic                    enable_i,
  input  logic [CNTR_W-1:0]       filter_len_i,
  input  logic                    glitch_clr_i,
  output logic                    scl_o,
  output logic                    sda_o,
  output logic                    scl_posedge_o,
  output logic                    scl_negedge_o,
  output logic                    sda_posedge_o,
  output logic                    sda_negedge_o,
  output logic [GLITCH_CNT_W-1:0] scl_glitch_cnt_o,
  output logic [GLITCH_CNT_W-1:0] sda_glitch_cnt_o
);

  logic [I3C_NUM_LINES-1:0] w_raw;
  i3c_line_t                w_line   [I3C_NUM_LINES];
  logic [GLITCH_CNT_W-1:0]  w_glitch [I3C_NUM_LINES];

  assign w_raw[I3C_IDX_SCL] = scl_i;
  assign w_raw[I3C_IDX_SDA] = sda_i;

  // Enable, filter length and clear fan out identically to every lane.
  generate
    for (genvar gi = 0; gi < I3C_NUM_LINES; gi++) begin : g_line
      i3c_line_conditioner_line_filter #(
        .CNTR_W       (CNTR_W),
        .SYNC_STAGES  (SYNC_STAGES),
        .GLITCH_CNT_W (GLITCH_CNT_W)
      ) u_filter (
        .clk_i        (clk_i),
        .rst_ni       (rst_ni),
        .line_i       (w_raw[gi]),
        .enable_i     (enable_i),
        .filter_len_i (filter_len_i),
        .glitch_clr_i (glitch_clr_i),
        .line_o       (w_line[gi].level),
        .posedge_o    (w_line[gi].rise),
        .negedge_o    (w_line[gi].fall),
        .glitch_cnt_o (w_glitch[gi])
      );
    end
  endgenerate

  assign scl_o            = w_line[I3C_IDX_SCL].level;
  assign scl_posedge_o    = w_line[I3C_IDX_SCL].rise;
  assign scl_negedge_o    = w_line[I3C_IDX_SCL].fall;
  assign scl_glitch_cnt_o = w_glitch[I3C_IDX_SCL];

  assign sda_o            = w_line[I3C_IDX_SDA].level;
  assign sda_posedge_o    = w_line[I3C_IDX_SDA].rise;
  assign sda_negedge_o    = w_line[I3C_IDX_SDA].fall;
  assign sda_glitch_cnt_o = w_glitch[I3C_IDX_SDA];

endmodule

// File: tb/tb_i3c_line_conditioner.sv
module tb_i3c_line_conditioner;

  localparam int CNTR_W      = 20;
  localparam int SYNC_STAGES = 2;
  localparam int GCW         = 8;
  localparam int GMAX        = (1 << GCW) - 1;

  logic              clk_i = 1'b0;
  logic              rst_ni;
  logic              scl_i, sda_i, enable_i, glitch_clr_i;
  logic [CNTR_W-1:0] filter_len_i;
  logic              scl_o, sda_o;
  logic              scl_posedge_o, scl_negedge_o, sda_posedge_o, sda_negedge_o;
  logic [GCW-1:0]    scl_glitch_cnt_o, sda_glitch_cnt_o;

  int checks   = 0;
  int failures = 0;

  i3c_line_conditioner #(
    .CNTR_W       (CNTR_W),
    .SYNC_STAGES  (SYNC_STAGES),
    .GLITCH_CNT_W (GCW)
  ) dut (
    .clk_i            (clk_i),
    .rst_ni           (rst_ni),
    .scl_i            (scl_i),
    .sda_i            (sda_i),
    .enable_i         (enable_i),
    .filter_len_i     (filter_len_i),
    .glitch_clr_i     (glitch_clr_i),
    .scl_o            (scl_o),
    .sda_o            (sda_o),
    .scl_posedge_o    (scl_posedge_o),
    .scl_negedge_o    (scl_negedge_o),
    .sda_posedge_o    (sda_posedge_o),
    .sda_negedge_o    (sda_negedge_o),
    .scl_glitch_cnt_o (scl_glitch_cnt_o),
    .sda_glitch_cnt_o (sda_glitch_cnt_o)
  );

  always #5 clk_i = ~clk_i;

  initial begin
    #2ms;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // ---------------- behavioural reference model -------------------------
  // Each line: the pad value is seen by the filter SYNC_STAGES edges after
  // it was sampled (pin_hist, oldest first). A disagreement between that
  // value and the output is accepted once it has lasted filter_len+1 edges;
  // a disagreement that vanishes earlier is one rejected spike.
  bit m_pin_hist [2][SYNC_STAGES];
  bit m_f   [2];
  bit m_pos [2];
  bit m_neg [2];
  int m_disagree [2];   // edges the current disagreement has lasted so far
  int m_gcnt [2];

  task automatic model_reset();
    for (int i = 0; i < 2; i++) begin
      for (int k = 0; k < SYNC_STAGES; k++) m_pin_hist[i][k] = 1'b1;
      m_f[i] = 1'b1; m_pos[i] = 1'b0; m_neg[i] = 1'b0;
      m_disagree[i] = 0; m_gcnt[i] = 0;
    end
  endtask

  task automatic model_edge();
    bit pin, seen;
    for (int i = 0; i < 2; i++) begin
      pin  = (i == 0) ? scl_i : sda_i;
      seen = m_pin_hist[i][0];
      for (int k = 0; k < SYNC_STAGES - 1; k++) m_pin_hist[i][k] = m_pin_hist[i][k+1];
      m_pin_hist[i][SYNC_STAGES-1] = pin;
      m_pos[i] = 1'b0; m_neg[i] = 1'b0;
      if (!enable_i) begin
        m_f[i] = 1'b1; m_disagree[i] = 0;
      end else if (seen == m_f[i]) begin
        if (m_disagree[i] > 0 && m_gcnt[i] < GMAX) m_gcnt[i] = m_gcnt[i] + 1;
        m_disagree[i] = 0;
      end else if (m_disagree[i] + 1 > int'(filter_len_i)) begin
        m_f[i] = seen; m_pos[i] = seen; m_neg[i] = !seen; m_disagree[i] = 0;
      end else begin
        m_disagree[i] = m_disagree[i] + 1;
      end
      if (glitch_clr_i) m_gcnt[i] = 0;
    end
  endtask

  function automatic logic [5:0] exp_vec();
    return {m_f[0], m_f[1], m_pos[0], m_neg[0], m_pos[1], m_neg[1]};
  endfunction

  function automatic logic [5:0] dut_vec();
    return {scl_o, sda_o, scl_posedge_o, scl_negedge_o, sda_posedge_o, sda_negedge_o};
  endfunction

  // Advance one clock: model the edge, then sample just after it.
  task automatic tick();
    model_edge();
    @(posedge clk_i);
    #1;
  endtask

  task automatic do_reset();
    rst_ni = 1'b0; scl_i = 1'b1; sda_i = 1'b1; enable_i = 1'b1;
    glitch_clr_i = 1'b0; filter_len_i = CNTR_W'(4);
    repeat (2) @(posedge clk_i);
    model_reset();
    @(negedge clk_i);
    rst_ni = 1'b1;
  endtask

  // ---------------- tests ----------------------------------------------
  task automatic test_reset();
    int bad = 0;
    do_reset();
    checks++;
    if (dut_vec() !== 6'b110000 || scl_glitch_cnt_o !== 8'd0 || sda_glitch_cnt_o !== 8'd0) begin
      failures++;
      $display("FAIL reset_values got vec=%b gc=%0d/%0d want vec=110000 gc=0/0",
               dut_vec(), scl_glitch_cnt_o, sda_glitch_cnt_o);
    end
    for (int n = 0; n < 20; n++) begin
      tick();
      checks++;
      if (dut_vec() !== 6'b110000 || scl_glitch_cnt_o !== 8'd0 || sda_glitch_cnt_o !== 8'd0) begin
        failures++; bad++;
        $display("FAIL reset_idle cycle=%0d got vec=%b gc=%0d/%0d want vec=110000 gc=0/0",
                 n, dut_vec(), scl_glitch_cnt_o, sda_glitch_cnt_o);
      end
    end
    $display("test_reset: 20 idle cycles, bad=%0d", bad);
  endtask

  task automatic test_sda_fall();
    int first = -1, pulses = 0;
    sda_i = 1'b0;
    for (int n = 1; n <= 20; n++) begin
      tick();
      if (sda_negedge_o === 1'b1) begin
        pulses++;
        if (first < 0) first = n;
      end
      checks++;
      if (dut_vec() !== exp_vec()) begin
        failures++;
        $display("FAIL sda_fall_model cycle=%0d got=%b want=%b", n, dut_vec(), exp_vec());
      end
    end
    checks++;
    if (first != 7 || pulses != 1) begin
      failures++;
      $display("FAIL sda_fall_latency got first=%0d pulses=%0d want first=7 pulses=1", first, pulses);
    end
    checks++;
    if (sda_o !== 1'b0 || sda_glitch_cnt_o !== 8'd0) begin
      failures++;
      $display("FAIL sda_fall_level got sda_o=%b gc=%0d want sda_o=0 gc=0", sda_o, sda_glitch_cnt_o);
    end
    $display("test_sda_fall: negedge at cycle %0d, pulses=%0d", first, pulses);
  endtask

  task automatic test_spike();
    int scl_low = 0, pos = 0, neg = 0;
    sda_i = 1'b1;
    repeat (10) tick();
    // 3-cycle spike: shorter than filter_len+1, must be rejected
    scl_i = 1'b0;
    for (int n = 0; n < 15; n++) begin
      if (n == 3) scl_i = 1'b1;
      tick();
      if (scl_o !== 1'b1 || scl_posedge_o !== 1'b0 || scl_negedge_o !== 1'b0) scl_low++;
      checks++;
      if (dut_vec() !== exp_vec()) begin
        failures++;
        $display("FAIL spike3_model cycle=%0d got=%b want=%b", n, dut_vec(), exp_vec());
      end
    end
    checks++;
    if (scl_low != 0 || scl_glitch_cnt_o !== 8'd1) begin
      failures++;
      $display("FAIL spike3_reject got disturbed=%0d gc=%0d want disturbed=0 gc=1", scl_low, scl_glitch_cnt_o);
    end
    // 5-cycle low: exactly filter_len+1, must pass through
    scl_i = 1'b0;
    for (int n = 0; n < 20; n++) begin
      if (n == 5) scl_i = 1'b1;
      tick();
      if (scl_posedge_o === 1'b1) pos++;
      if (scl_negedge_o === 1'b1) neg++;
      checks++;
      if (dut_vec() !== exp_vec()) begin
        failures++;
        $display("FAIL spike5_model cycle=%0d got=%b want=%b", n, dut_vec(), exp_vec());
      end
    end
    checks++;
    if (pos != 1 || neg != 1 || scl_glitch_cnt_o !== 8'd1 || scl_o !== 1'b1) begin
      failures++;
      $display("FAIL spike5_pass got pos=%0d neg=%0d gc=%0d scl=%b want pos=1 neg=1 gc=1 scl=1",
               pos, neg, scl_glitch_cnt_o, scl_o);
    end
    $display("test_spike: 3-cycle rejected, 5-cycle passed (pos=%0d neg=%0d)", pos, neg);
  endtask

  task automatic test_zero_len();
    logic want;
    filter_len_i = '0;
    repeat (6) tick();
    for (int t = 0; t < 10; t++) begin
      sda_i = ~sda_i;
      if (t >= 8) scl_i = ~scl_i;     // last two toggles hit both lines together
      for (int k = 1; k <= 4; k++) begin
        tick();
        want = (k == 3);
        checks++;
        if ((sda_posedge_o | sda_negedge_o) !== want) begin
          failures++;
          $display("FAIL zero_len_sda toggle=%0d cycle=%0d got pulse=%b want %b",
                   t, k, sda_posedge_o | sda_negedge_o, want);
        end
        if (t >= 8) begin
          checks++;
          if ((scl_posedge_o | scl_negedge_o) !== want) begin
            failures++;
            $display("FAIL zero_len_scl toggle=%0d cycle=%0d got pulse=%b want %b",
                     t, k, scl_posedge_o | scl_negedge_o, want);
          end
        end
        checks++;
        if (dut_vec() !== exp_vec()) begin
          failures++;
          $display("FAIL zero_len_model toggle=%0d cycle=%0d got=%b want=%b", t, k, dut_vec(), exp_vec());
        end
      end
    end
    $display("test_zero_len: 10 toggles with latency 3, last 2 on both lines");
  endtask

  task automatic test_saturation();
    filter_len_i = CNTR_W'(4);
    scl_i = 1'b1; sda_i = 1'b1;
    repeat (12) tick();
    for (int n = 0; n < 300; n++) begin
      sda_i = 1'b0; repeat (2) tick();
      sda_i = 1'b1; repeat (6) tick();
      checks++;
      if (sda_glitch_cnt_o !== GCW'(m_gcnt[1]) || dut_vec() !== exp_vec()) begin
        failures++;
        $display("FAIL sat_step spike=%0d got gc=%0d vec=%b want gc=%0d vec=%b",
                 n, sda_glitch_cnt_o, dut_vec(), m_gcnt[1], exp_vec());
      end
    end
    checks++;
    if (sda_glitch_cnt_o !== 8'd255) begin
      failures++;
      $display("FAIL sat_value got=%0d want=255", sda_glitch_cnt_o);
    end
    // one more spike; clear coincides with the edge that would count it
    sda_i = 1'b0; repeat (2) tick();
    sda_i = 1'b1; repeat (2) tick();
    glitch_clr_i = 1'b1; tick(); glitch_clr_i = 1'b0;
    checks++;
    if (sda_glitch_cnt_o !== 8'd0 || scl_glitch_cnt_o !== 8'd0) begin
      failures++;
      $display("FAIL clr_wins got sda_gc=%0d scl_gc=%0d want 0/0", sda_glitch_cnt_o, scl_glitch_cnt_o);
    end
    repeat (4) tick();
    checks++;
    if (sda_glitch_cnt_o !== 8'd0) begin
      failures++;
      $display("FAIL clr_hold got=%0d want=0", sda_glitch_cnt_o);
    end
    $display("test_saturation: 300 spikes saturated, clear beat increment");
  endtask

  task automatic test_enable_reset();
    int first = -1;
    enable_i = 1'b0; sda_i = 1'b0;
    for (int n = 0; n < 6; n++) begin
      tick();
      checks++;
      if (sda_o !== 1'b1 || sda_posedge_o !== 1'b0 || sda_negedge_o !== 1'b0) begin
        failures++;
        $display("FAIL disabled cycle=%0d got sda_o=%b pos=%b neg=%b want 1 0 0",
                 n, sda_o, sda_posedge_o, sda_negedge_o);
      end
    end
    filter_len_i = CNTR_W'(2); enable_i = 1'b1;
    for (int n = 1; n <= 8; n++) begin
      tick();
      if (sda_negedge_o === 1'b1 && first < 0) first = n;
      checks++;
      if (dut_vec() !== exp_vec()) begin
        failures++;
        $display("FAIL enable_model cycle=%0d got=%b want=%b", n, dut_vec(), exp_vec());
      end
    end
    checks++;
    if (first != 3) begin
      failures++;
      $display("FAIL enable_latency got=%0d want=3", first);
    end
    // put a spike count in place, then reset in the middle of a rising count
    filter_len_i = CNTR_W'(4);
    scl_i = 1'b0; repeat (2) tick(); scl_i = 1'b1; repeat (4) tick();
    sda_i = 1'b1; repeat (4) tick();
    #2 rst_ni = 1'b0;
    #1;
    model_reset();
    checks++;
    if (dut_vec() !== 6'b110000 || scl_glitch_cnt_o !== 8'd0 || sda_glitch_cnt_o !== 8'd0) begin
      failures++;
      $display("FAIL async_reset got vec=%b gc=%0d/%0d want vec=110000 gc=0/0",
               dut_vec(), scl_glitch_cnt_o, sda_glitch_cnt_o);
    end
    @(negedge clk_i); rst_ni = 1'b1;
    for (int n = 0; n < 8; n++) begin
      tick();
      checks++;
      if (dut_vec() !== 6'b110000) begin
        failures++;
        $display("FAIL reset_release cycle=%0d got=%b want=110000", n, dut_vec());
      end
    end
    $display("test_enable_reset: enable negedge at cycle %0d, async reset checked", first);
  endtask

  task automatic test_random();
    int hold [2];
    int bad = 0;
    hold[0] = 1; hold[1] = 1;
    for (int n = 0; n < 4000; n++) begin
      for (int i = 0; i < 2; i++) begin
        hold[i] = hold[i] - 1;
        if (hold[i] == 0) begin
          if (i == 0) scl_i = 1'($urandom_range(0, 1));
          else        sda_i = 1'($urandom_range(0, 1));
          hold[i] = $urandom_range(1, 9);
        end
      end
      if ($urandom_range(0, 39) == 0) filter_len_i = CNTR_W'($urandom_range(0, 5));
      if (!enable_i) begin
        if ($urandom_range(0, 15) == 0) enable_i = 1'b1;
      end else if ($urandom_range(0, 199) == 0) begin
        enable_i = 1'b0;
      end
      glitch_clr_i = ($urandom_range(0, 299) == 0);
      tick();
      checks++;
      if (dut_vec() !== exp_vec() || scl_glitch_cnt_o !== GCW'(m_gcnt[0]) ||
          sda_glitch_cnt_o !== GCW'(m_gcnt[1])) begin
        failures++; bad++;
        $display("FAIL random cycle=%0d got vec=%b gc=%0d/%0d want vec=%b gc=%0d/%0d",
                 n, dut_vec(), scl_glitch_cnt_o, sda_glitch_cnt_o,
                 exp_vec(), m_gcnt[0], m_gcnt[1]);
      end
    end
    glitch_clr_i = 1'b0; enable_i = 1'b1;
    $display("test_random: 4000 cycles, final gc=%0d/%0d, bad=%0d", m_gcnt[0], m_gcnt[1], bad);
  endtask

  initial begin
    test_reset();
    test_sda_fall();
    test_spike();
    test_zero_len();
    test_saturation();
    test_enable_reset();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
